dpram_port_arbiter: RTL
=======================

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: address width; RAM depth 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8: data width, one byte.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid_a / req_valid_b  input  1  client request valid, per port.
REQ-006 req_ready_a / req_ready_b  output  1  request accepted this cycle when valid and ready are both 1.
REQ-007 req_we_a / req_we_b  input  1  1 = write, 0 = read.
REQ-008 req_addr_a / req_addr_b  input  ADDR_W  request address.
REQ-009 req_wdata_a / req_wdata_b  input  DATA_W  write data.
REQ-010 rsp_valid_a / rsp_valid_b  output  1  read data valid; no backpressure.
REQ-011 rsp_rdata_a / rsp_rdata_b  output  DATA_W  read data.
REQ-012 ram_en_a / ram_en_b, ram_we_a / ram_we_b  output  1  RAM port enable and write enable.
REQ-013 ram_addr_a / ram_addr_b  output  ADDR_W; ram_wdata_a / ram_wdata_b  output  DATA_W  RAM port address and data.
REQ-014 ram_rdata_a / ram_rdata_b  input  DATA_W  RAM read data, valid the cycle after a read enable.
REQ-015 coll_cnt  output  16  count of resolved collisions.

Function
REQ-016 Collision SHALL be: req_valid_a & req_valid_b & (req_addr_a == req_addr_b) & (req_we_a | req_we_b); read/read to the same address is not a collision.
REQ-017 With no collision, req_ready_a = req_ready_b = 1.
REQ-018 On collision, only the priority port SHALL get ready=1; the other port SHALL get ready=0 and its RAM enable SHALL be 0.
REQ-019 Priority FSM states PRI_A and PRI_B; reset state PRI_A.
REQ-020 On each collision cycle, the FSM SHALL move to the state favouring the loser (PRI_A->PRI_B if A won, PRI_B->PRI_A if B won); otherwise it SHALL hold.
REQ-021 ram_en_p = req_valid_p & req_ready_p (combinational); ram_we_p, ram_addr_p and ram_wdata_p SHALL pass through from the port p request.
REQ-022 When ram_en_p = 0, ram_we_p SHALL be 0 (addr/wdata are don't-care).
REQ-023 An accepted read on port p SHALL give rsp_valid_p = 1 exactly one cycle later, with rsp_rdata_p = ram_rdata_p in that cycle; read latency is 1.
REQ-024 When rsp_valid_p = 0, rsp_rdata_p SHALL be 0.
REQ-025 Accepted writes SHALL produce no response.
REQ-026 Back-to-back accepted reads SHALL give back-to-back rsp_valid pulses, one per read, in order.
REQ-027 coll_cnt SHALL increment by 1 per collision cycle and saturate at 16'hFFFF.
REQ-028 Address wrap: 0 and 2**ADDR_W-1 are ordinary addresses, with no special handling.
REQ-029 A loser that keeps req_valid asserted SHALL be accepted on the next cycle if the winner does not present a new collision; under a continuous collision the ports SHALL alternate, so neither is starved for more than 1 cycle.
REQ-030 Changing request fields while valid=1 and ready=0 is legal; arbitration always uses current-cycle values.

Reset
REQ-031 While rst_n = 0: FSM = PRI_A, rsp_valid_a = rsp_valid_b = 0, rsp_rdata = 0, coll_cnt = 0; applied immediately, without waiting for clk.
REQ-032 While rst_n = 0, req_ready_a/b and ram_en_a/b SHALL be 0.
REQ-033 Reads accepted in the cycle before reset asserts SHALL NOT produce a response after reset releases.
REQ-034 The first clk edge after rst_n rises SHALL be a normal operating edge.

Verification
REQ-035 A: read 0x10, B: read 0x10 in the same cycle -> both ready; next cycle rsp_valid_a = rsp_valid_b = 1 with RAM data; coll_cnt = 0.
REQ-036 A: write 0x55 to 0xFF, B: read 0xFF, both held valid from reset -> cycle 1: A only, coll_cnt = 1, FSM = PRI_B; cycle 2: B read accepted; cycle 3: rsp_rdata_b = 0x55.
REQ-037 Both ports write to 0x00 continuously for 4 cycles -> accepted order A, B, A, B; coll_cnt = 4.
REQ-038 A issues reads to 0x01, 0x02, 0x03 on consecutive cycles -> rsp_valid_a high for 3 consecutive cycles, data in order.
REQ-039 Assert rst_n = 0 mid-cycle after an accepted read -> rsp_valid low at once; no response after release; coll_cnt = 0.
REQ-040 Force 65536 collisions -> coll_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/dpram_port_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dpram_port_arbiter_if
//
// Bundles everything that crosses the arbiter boundary apart from clk, rst_n
// and the collision counter: the two client request/response channels (A, B)
// and the two true-dual-port RAM ports behind the arbiter.
//
// Modports
//   slave  : the arbiter. Consumes client requests and RAM read data; drives
//            request ready, read responses and the RAM port controls.
//   master : the environment (clients plus the RAM itself). Drives requests
//            and RAM read data; consumes everything the arbiter produces.
//
// Client channel, per port p in {a, b}
//   req_valid_p / req_ready_p : request handshake, accepted when both are 1
//   req_we_p                  : 1 = write, 0 = read
//   req_addr_p / req_wdata_p  : request address and write data
//   rsp_valid_p / rsp_rdata_p : read response, one cycle after acceptance
// RAM port, per port p
//   ram_en_p / ram_we_p       : port enable and write enable
//   ram_addr_p / ram_wdata_p  : port address and write data
//   ram_rdata_p               : read data, valid the cycle after a read enable
// ---------------------------------------------------------------------------
interface dpram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Client side
    logic              req_valid_a, req_valid_b;
    logic              req_ready_a, req_ready_b;
    logic              req_we_a,    req_we_b;
    logic [ADDR_W-1:0] req_addr_a,  req_addr_b;
    logic [DATA_W-1:0] req_wdata_a, req_wdata_b;
    logic              rsp_valid_a, rsp_valid_b;
    logic [DATA_W-1:0] rsp_rdata_a, rsp_rdata_b;

    // RAM side
    logic              ram_en_a,    ram_en_b;
    logic              ram_we_a,    ram_we_b;
    logic [ADDR_W-1:0] ram_addr_a,  ram_addr_b;
    logic [DATA_W-1:0] ram_wdata_a, ram_wdata_b;
    logic [DATA_W-1:0] ram_rdata_a, ram_rdata_b;

    modport slave (
        input  req_valid_a, req_valid_b,
        input  req_we_a,    req_we_b,
        input  req_addr_a,  req_addr_b,
        input  req_wdata_a, req_wdata_b,
        output req_ready_a, req_ready_b,
        output rsp_valid_a, rsp_valid_b,
        output rsp_rdata_a, rsp_rdata_b,
        output ram_en_a,    ram_en_b,
        output ram_we_a,    ram_we_b,
        output ram_addr_a,  ram_addr_b,
        output ram_wdata_a, ram_wdata_b,
        input  ram_rdata_a, ram_rdata_b
    );

    modport master (
        output req_valid_a, req_valid_b,
        output req_we_a,    req_we_b,
        output req_addr_a,  req_addr_b,
        output req_wdata_a, req_wdata_b,
        input  req_ready_a, req_ready_b,
        input  rsp_valid_a, rsp_valid_b,
        input  rsp_rdata_a, rsp_rdata_b,
        input  ram_en_a,    ram_en_b,
        input  ram_we_a,    ram_we_b,
        input  ram_addr_a,  ram_addr_b,
        input  ram_wdata_a, ram_wdata_b,
        output ram_rdata_a, ram_rdata_b
    );
endinterface : dpram_port_arbiter_if

// File: rtl/dpram_port_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dpram_port_arbiter
//
// Front end for a true dual-port RAM shared by two clients. Each client owns
// one RAM port, so requests normally pass straight through. The only hazard
// is two requests hitting the same address where at least one writes; in that
// cycle one port is stalled (ready = 0, RAM enable = 0) and the other goes
// through. A two-state priority FSM hands the next collision to whichever
// port lost the last one, so a loser that keeps its request up is served on
// the following cycle at the latest.
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : dpram_port_arbiter_if.slave (client channels + RAM ports)
//   coll_cnt : number of collision cycles seen, saturating at 16'hFFFF
//
// Read path: an accepted read enables the RAM port this cycle; the RAM
// returns data the next cycle, which is forwarded with rsp_valid. Writes
// produce no response.
// ---------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpram_port_arbiter_if.slave  bus,
    output logic [15:0]          coll_cnt
);

    typedef enum logic {
        PRI_A = 1'b0,   // port A wins the next collision
        PRI_B = 1'b1    // port B wins the next collision
    } pri_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    pri_e        pri_q, pri_d;
    logic [15:0] coll_cnt_q, coll_cnt_d;
    logic        rsp_valid_a_q, rsp_valid_b_q;

    logic        collision;
    logic        ready_a, ready_b;
    logic        en_a, en_b;

    // -----------------------------------------------------------------------
    // Arbitration and next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        collision  = 1'b0;
        ready_a    = 1'b0;
        ready_b    = 1'b0;
        pri_d      = pri_q;
        coll_cnt_d = coll_cnt_q;

        // Read/read to one address is harmless: both RAM ports may read it.
        collision = bus.req_valid_a && bus.req_valid_b &&
                    (bus.req_addr_a == bus.req_addr_b) &&
                    (bus.req_we_a || bus.req_we_b);

        // Ready is forced low while reset is held so nothing reaches the RAM.
        if (rst_n) begin
            ready_a = !collision || (pri_q == PRI_A);
            ready_b = !collision || (pri_q == PRI_B);
        end

        // Hand the next collision to the port that just lost.
        if (collision) begin
            pri_d = (pri_q == PRI_A) ? PRI_B : PRI_A;
            if (coll_cnt_q != CNT_MAX) begin
                coll_cnt_d = coll_cnt_q + 16'd1;
            end
        end

        en_a = bus.req_valid_a && ready_a;
        en_b = bus.req_valid_b && ready_b;
    end

    // -----------------------------------------------------------------------
    // State: priority FSM, collision counter, read-response flags
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value regardless of statement order.
    // Clearing the response flags on reset also discards any read accepted
    // just before reset asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q         <= PRI_A;
            coll_cnt_q    <= '0;
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
        end else begin
            pri_q         <= pri_d;
            coll_cnt_q    <= coll_cnt_d;
            rsp_valid_a_q <= en_a && !bus.req_we_a;
            rsp_valid_b_q <= en_b && !bus.req_we_b;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready_a = ready_a;
    assign bus.req_ready_b = ready_b;

    assign bus.ram_en_a    = en_a;
    assign bus.ram_en_b    = en_b;
    assign bus.ram_we_a    = en_a && bus.req_we_a;
    assign bus.ram_we_b    = en_b && bus.req_we_b;
    assign bus.ram_addr_a  = bus.req_addr_a;
    assign bus.ram_addr_b  = bus.req_addr_b;
    assign bus.ram_wdata_a = bus.req_wdata_a;
    assign bus.ram_wdata_b = bus.req_wdata_b;

    // RAM data arrives the cycle after the enable, which is exactly the cycle
    // the response flag is high; outside that window the data bus reads 0.
    assign bus.rsp_valid_a = rsp_valid_a_q;
    assign bus.rsp_valid_b = rsp_valid_b_q;
    assign bus.rsp_rdata_a = rsp_valid_a_q ? bus.ram_rdata_a : '0;
    assign bus.rsp_rdata_b = rsp_valid_b_q ? bus.ram_rdata_b : '0;

    assign coll_cnt = coll_cnt_q;

endmodule : dpram_port_arbiter
